// File: rtl/if_stage_btb.sv
// if_stage_btb
//   Instruction-fetch stage. Owns the PC, drives the instruction-memory address
//   and predicts the next PC with a direct-mapped BTB that holds a 2-bit
//   saturating counter per entry. The fetched instruction is registered into
//   the IF/ID boundary together with its PC, PC+4 and the prediction bit.
//
//   Optional feature macro: BTB_FWD_EN
//     If it is defined, a BTB update whose index matches this cycle's lookup
//     index is bypassed into the lookup, so the prediction sees the post-update
//     entry. If it is undefined, the lookup always reads the registered entry.
//
// Ports
//   clk               clock, rising edge
//   rstn              asynchronous active-low reset
//   stall             holds the PC and the IF/ID registers
//   pc_change_EX      redirect from EX; takes priority over stall
//   pc_nxt_EX [31:0]  redirect target
//   record_we         write branch history this cycle
//   record_data       resolved outcome (1 = taken)
//   record_pc [31:0]  PC of the resolved instruction
//   record_pc_result  resolved next PC (the target when taken)
//   imem_addr [31:0]  instruction-memory address (= PC register)
//   imem_data [31:0]  instruction read of imem_addr
//   pc_IF, pc_4_IF, inst_IF, predict_IF   IF/ID registers

module if_stage_btb #(
    parameter int          BTB_IDX_W = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        pc_change_EX,
    input  logic [31:0] pc_nxt_EX,
    input  logic        record_we,
    input  logic        record_data,
    input  logic [31:0] record_pc,
    input  logic [31:0] record_pc_result,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_IF,
    output logic [31:0] pc_4_IF,
    output logic [31:0] inst_IF,
    output logic        predict_IF
);

    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = 30 - BTB_IDX_W;

    logic [31:0]          pc;
    logic                 btb_valid  [ENTRIES];
    logic [TAG_W-1:0]     btb_tag    [ENTRIES];
    logic [31:0]          btb_target [ENTRIES];
    logic [1:0]           btb_cnt    [ENTRIES];

    logic [BTB_IDX_W-1:0] look_idx;
    logic [TAG_W-1:0]     look_tag;
    logic [BTB_IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 upd_hit;
    logic                 upd_wr;
    logic                 new_valid;
    logic [TAG_W-1:0]     new_tag;
    logic [31:0]          new_target;
    logic [1:0]           new_cnt;

    logic                 ent_valid;
    logic [TAG_W-1:0]     ent_tag;
    logic [31:0]          ent_target;
    logic [1:0]           ent_cnt;
    logic                 hit;
    logic                 pred_taken;
    logic [31:0]          pc_plus4;
    logic [31:0]          next_pc;

    assign imem_addr = pc;
    assign look_idx  = pc[BTB_IDX_W+1:2];
    assign look_tag  = pc[31:BTB_IDX_W+2];
    assign upd_idx   = record_pc[BTB_IDX_W+1:2];
    assign upd_tag   = record_pc[31:BTB_IDX_W+2];
    assign upd_hit   = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    // New contents of the entry addressed by record_pc. A not-taken miss
    // never allocates; a taken miss replaces whatever was in the slot.
    always_comb begin
        upd_wr     = 1'b0;
        new_valid  = btb_valid[upd_idx];
        new_tag    = btb_tag[upd_idx];
        new_target = btb_target[upd_idx];
        new_cnt    = btb_cnt[upd_idx];
        if (record_we) begin
            if (upd_hit) begin
                upd_wr = 1'b1;
                if (record_data) begin
                    new_cnt    = (btb_cnt[upd_idx] == 2'b11) ? 2'b11 : btb_cnt[upd_idx] + 2'b01;
                    new_target = record_pc_result;
                end else begin
                    new_cnt    = (btb_cnt[upd_idx] == 2'b00) ? 2'b00 : btb_cnt[upd_idx] - 2'b01;
                end
            end else if (record_data) begin
                upd_wr     = 1'b1;
                new_valid  = 1'b1;
                new_tag    = upd_tag;
                new_target = record_pc_result;
                new_cnt    = 2'b10;
            end
        end
    end

    always_comb begin
        ent_valid  = btb_valid[look_idx];
        ent_tag    = btb_tag[look_idx];
        ent_target = btb_target[look_idx];
        ent_cnt    = btb_cnt[look_idx];
`ifdef BTB_FWD_EN
        if (upd_wr && (upd_idx == look_idx)) begin
            ent_valid  = new_valid;
            ent_tag    = new_tag;
            ent_target = new_target;
            ent_cnt    = new_cnt;
        end
`endif
    end

    assign hit        = ent_valid && (ent_tag == look_tag);
    assign pred_taken = hit && ent_cnt[1];
    assign pc_plus4   = pc + 32'd4;
    assign next_pc    = pred_taken ? ent_target : pc_plus4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc         <= RESET_PC;
            pc_IF      <= 32'd0;
            pc_4_IF    <= 32'd0;
            inst_IF    <= NOP_INST;
            predict_IF <= 1'b0;
        end else if (pc_change_EX) begin
            pc         <= pc_nxt_EX;
            pc_IF      <= 32'd0;
            pc_4_IF    <= 32'd0;
            inst_IF    <= NOP_INST;
            predict_IF <= 1'b0;
        end else if (!stall) begin
            pc         <= next_pc;
            pc_IF      <= pc;
            pc_4_IF    <= pc_plus4;
            inst_IF    <= imem_data;
            predict_IF <= pred_taken;
        end
    end

    // History updates are independent of stall and redirect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= 32'd0;
                btb_cnt[i]    <= 2'b00;
            end
        end else if (upd_wr) begin
            btb_valid[upd_idx]  <= new_valid;
            btb_tag[upd_idx]    <= new_tag;
            btb_target[upd_idx] <= new_target;
            btb_cnt[upd_idx]    <= new_cnt;
        end
    end

endmodule

// File: tb/tb_if_stage_btb.sv
// tb_if_stage_btb
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural fetch/BTB model kept in the bench.
//   Uses BTB_FWD_EN the same way as the design build.

module tb_if_stage_btb;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NE  = 16;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        pc_change_EX;
    logic [31:0] pc_nxt_EX;
    logic        record_we;
    logic        record_data;
    logic [31:0] record_pc;
    logic [31:0] record_pc_result;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_IF;
    logic [31:0] pc_4_IF;
    logic [31:0] inst_IF;
    logic        predict_IF;

    int n_vec;
    int n_err;

    // behavioural model state
    logic [31:0] m_pc, m_pc_if, m_pc4, m_inst;
    logic        m_pred;
    bit          m_valid [NE];
    logic [31:0] m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_cnt   [NE];

    if_stage_btb dut (
        .clk              (clk),
        .rstn             (rstn),
        .stall            (stall),
        .pc_change_EX     (pc_change_EX),
        .pc_nxt_EX        (pc_nxt_EX),
        .record_we        (record_we),
        .record_data      (record_data),
        .record_pc        (record_pc),
        .record_pc_result (record_pc_result),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .pc_IF            (pc_IF),
        .pc_4_IF          (pc_4_IF),
        .inst_IF          (inst_IF),
        .predict_IF       (predict_IF)
    );

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_data = imem_fn(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'd0;
        m_pc_if = 32'd0;
        m_pc4   = 32'd0;
        m_inst  = NOP;
        m_pred  = 1'b0;
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'd0;
            m_tgt[i]   = 32'd0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic check_outputs();
        chk("imem_addr",  imem_addr,         m_pc);
        chk("pc_IF",      pc_IF,             m_pc_if);
        chk("pc_4_IF",    pc_4_IF,           m_pc4);
        chk("inst_IF",    inst_IF,           m_inst);
        chk("predict_IF", {31'd0, predict_IF}, {31'd0, m_pred});
    endtask

    // Advance the model by one edge using the inputs currently driven, then
    // clock the DUT and compare.
    task automatic step();
        int          li, ri;
        bit          wr, lv, nv, pred;
        logic [31:0] lt, ltg, nt, ntg, nxt;
        int          lc, nc;
        ri  = (record_pc >> 2) % NE;
        nv  = m_valid[ri];
        nt  = m_tag[ri];
        ntg = m_tgt[ri];
        nc  = m_cnt[ri];
        wr  = 1'b0;
        if (record_we) begin
            if (m_valid[ri] && m_tag[ri] == (record_pc >> 6)) begin
                wr = 1'b1;
                if (record_data) begin
                    nc  = (m_cnt[ri] >= 3) ? 3 : m_cnt[ri] + 1;
                    ntg = record_pc_result;
                end else begin
                    nc  = (m_cnt[ri] <= 0) ? 0 : m_cnt[ri] - 1;
                end
            end else if (record_data) begin
                wr  = 1'b1;
                nv  = 1'b1;
                nt  = record_pc >> 6;
                ntg = record_pc_result;
                nc  = 2;
            end
        end
        li  = (m_pc >> 2) % NE;
        lv  = m_valid[li];
        lt  = m_tag[li];
        ltg = m_tgt[li];
        lc  = m_cnt[li];
`ifdef BTB_FWD_EN
        if (wr && ri == li) begin
            lv = nv; lt = nt; ltg = ntg; lc = nc;
        end
`endif
        pred = lv && (lt == (m_pc >> 6)) && (lc >= 2);
        nxt  = pred ? ltg : m_pc + 32'd4;
        if (pc_change_EX) begin
            m_pc    = pc_nxt_EX;
            m_pc_if = 32'd0;
            m_pc4   = 32'd0;
            m_inst  = NOP;
            m_pred  = 1'b0;
        end else if (!stall) begin
            m_pc_if = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_inst  = imem_fn(m_pc);
            m_pred  = pred;
            m_pc    = nxt;
        end
        if (wr) begin
            m_valid[ri] = nv;
            m_tag[ri]   = nt;
            m_tgt[ri]   = ntg;
            m_cnt[ri]   = nc;
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall        = 1'b0;
        pc_change_EX = 1'b0;
        pc_nxt_EX    = 32'd0;
        record_we    = 1'b0;
        record_data  = 1'b0;
        record_pc    = 32'd0;
        record_pc_result = 32'd0;
    endtask

    task automatic redirect(input logic [31:0] t);
        pc_change_EX = 1'b1;
        pc_nxt_EX    = t;
        step();
        pc_change_EX = 1'b0;
    endtask

    task automatic record(input logic [31:0] p, input logic d, input logic [31:0] r);
        record_we        = 1'b1;
        record_pc        = p;
        record_data      = d;
        record_pc_result = r;
    endtask

    // Reset asserted mid-cycle; outputs must change before any clock edge.
    task automatic reset_mid();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_inst_IF",   inst_IF,   NOP);
        chk("rst_pc_IF",     pc_IF,     32'd0);
        chk("rst_pred",      {31'd0, predict_IF}, 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] pick_pc();
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        return $urandom_range(0, 47) * 4;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check_outputs();

        // run a little, then reset asynchronously mid-operation
        record(32'h8, 1'b1, 32'h60);
        step();
        record_we = 1'b0;
        step();
        @(posedge clk);
        reset_mid();

        // sequential fetch after reset
        chk("t1_addr0", imem_addr, 32'h0);
        step(); chk("t1_addr4", imem_addr, 32'h4);  chk("t1_pcif0", pc_IF, 32'h0);
        step(); chk("t1_addr8", imem_addr, 32'h8);  chk("t1_pcif4", pc_IF, 32'h4);
        step(); chk("t1_pred0", {31'd0, predict_IF}, 32'd0);

        // redirect overrides stall
        stall = 1'b1;
        redirect(32'h40);
        stall = 1'b0;
        chk("t2_addr", imem_addr, 32'h40);
        chk("t2_inst", inst_IF, NOP);

        // allocate then predict
        record(32'h10, 1'b1, 32'h80);
        step();
        record_we = 1'b0;
        redirect(32'h10);
        step();
        chk("t3_pred",   {31'd0, predict_IF}, 32'd1);
        chk("t3_target", imem_addr, 32'h80);
        chk("t3_pcif",   pc_IF, 32'h10);

        // counter training
        record(32'h10, 1'b0, 32'h14);
        step();
        step();
        record_we = 1'b0;
        redirect(32'h10);
        step();
        chk("t4_nopred", {31'd0, predict_IF}, 32'd0);
        chk("t4_seq",    imem_addr, 32'h14);
        record(32'h10, 1'b1, 32'h80);
        step();
        record_we = 1'b0;
        redirect(32'h10);
        step();
        chk("t4_cnt01", {31'd0, predict_IF}, 32'd0);

        // stall hold with concurrent history write
        stall = 1'b1;
        record(32'h20, 1'b1, 32'h100);
        step();
        record_we = 1'b0;
        step();
        step();
        chk("t5_addr", imem_addr, 32'h14);
        chk("t5_pcif", pc_IF, 32'h10);
        stall = 1'b0;
        redirect(32'h20);
        step();
        chk("t5_pred", {31'd0, predict_IF}, 32'd1);
        chk("t5_tgt",  imem_addr, 32'h100);

        // alias at the same index, then same-cycle allocate/lookup
        redirect(32'h50);
        record(32'h10, 1'b1, 32'h200);
        step();
        record_we = 1'b0;
        chk("t6_alias", {31'd0, predict_IF}, 32'd0);
        chk("t6_addr",  imem_addr, 32'h54);
        redirect(32'h30);
        record(32'h30, 1'b1, 32'h300);
        step();
        record_we = 1'b0;
`ifdef BTB_FWD_EN
        chk("t6_fwd_pred", {31'd0, predict_IF}, 32'd1);
        chk("t6_fwd_addr", imem_addr, 32'h300);
`else
        chk("t6_nofwd_pred", {31'd0, predict_IF}, 32'd0);
        chk("t6_nofwd_addr", imem_addr, 32'h34);
`endif

        // 32-bit wrap
        redirect(32'hFFFF_FFFC);
        step();
        chk("wrap_pc4",  pc_4_IF, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stall            = ($urandom_range(0, 3) == 0);
            pc_change_EX     = ($urandom_range(0, 7) == 0);
            pc_nxt_EX        = pick_pc();
            record_we        = ($urandom_range(0, 2) == 0);
            record_data      = $urandom_range(0, 1);
            record_pc        = pick_pc();
            record_pc_result = pick_pc();
            if (n % 700 == 699) begin
                @(posedge clk);
                reset_mid();
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
